mem_refill_arbiter: RTL and testbench

//  Shares one 128-bit line memory (wsync_mem_o128-style: re + valid handshake) between two refill

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_refill_arbiter_rr_pick2.sv | 30 +++
 rtl/mem_refill_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_refill_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the two-requester line-refill arbiter.
//   arb_state_t : transaction FSM states (IDLE -> ISSUE -> WAIT -> RESP)
//   req_id_t    : requester identity (I-cache = port 0, D-cache = port 1)
//   LINE_W_DEF  : default refill line width
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
    typedef enum logic {REQ_I, REQ_D} req_id_t;

    localparam int LINE_W_DEF = 128;
    localparam int ADDR_W_DEF = 32;

endpackage

// File: rtl/mem_refill_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
// Ports:
//   i_req   [1:0]  request vector, bit 0 = I side, bit 1 = D side
//   i_last         requester granted most recently
//   o_grant        requester to serve now (valid when o_any)
//   o_any          at least one request present
// A lone request always wins; on a tie the side that did not win last time
// is chosen.
// ---------------------------------------------------------------------------
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_id_t    i_last,
    output req_id_t    o_grant,
    output logic       o_any
);

    always_comb begin
        o_any   = |i_req;
        o_grant = REQ_I;
        if (&i_req)
            o_grant = (i_last == REQ_I) ? REQ_D : REQ_I;
        else if (i_req[1])
            o_grant = REQ_D;
    end

endmodule

// File: rtl/mem_refill_arbiter.sv
// ---------------------------------------------------------------------------
// mem_refill_arbiter
// Shares one line memory (read strobe + data-valid handshake) between the
// I-cache and D-cache refill paths. One memory read is outstanding at a time;
// the returned line is pulsed only to the requester that owns the transaction.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   i_req_i / i_addr_i      I-side level request and line address
//   i_valid_o / i_data_o    I-side one-cycle line-valid pulse and line data
//   d_req_i / d_addr_i      D-side level request and line address
//   d_valid_o / d_data_o    D-side one-cycle line-valid pulse and line data
//   mem_re_o / mem_add_o    memory read strobe (one cycle) and address
//   mem_valid_i/mem_data_i  memory read-data valid and data
//   perf_i_cnt_o            I grants issued
//   perf_d_cnt_o            D grants issued
//   perf_cfl_o              grants made while both sides were requesting
//
// Build option: define ARB_PERF_EN to get the three wrapping performance
// counters; without it the perf outputs are constant zero.
// ---------------------------------------------------------------------------
module mem_refill_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_valid_o,
    output logic [LINE_W-1:0] i_data_o,
    input  logic              d_req_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    output logic              d_valid_o,
    output logic [LINE_W-1:0] d_data_o,
    output logic              mem_re_o,
    output logic [ADDR_W-1:0] mem_add_o,
    input  logic              mem_valid_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic [31:0]       perf_i_cnt_o,
    output logic [31:0]       perf_d_cnt_o,
    output logic [31:0]       perf_cfl_o
);

    arb_state_t        r_state;
    req_id_t           r_owner;
    req_id_t           r_last;
    logic              r_mem_re;
    logic [ADDR_W-1:0] r_mem_add;
    logic              r_i_valid;
    logic              r_d_valid;
    logic [LINE_W-1:0] r_i_data;
    logic [LINE_W-1:0] r_d_data;

    req_id_t           w_grant;
    logic              w_any;
    logic              w_grant_now;

    rr_pick2 u_pick (
        .i_req   ({d_req_i, i_req_i}),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    assign w_grant_now = (r_state == ARB_IDLE) && w_any;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ARB_IDLE;
            r_owner   <= REQ_I;
            r_last    <= REQ_D;
            r_mem_re  <= 1'b0;
            r_mem_add <= '0;
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            r_i_data  <= '0;
            r_d_data  <= '0;
        end else begin
            r_mem_re  <= 1'b0;
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_owner   <= w_grant;
                        r_last    <= w_grant;
                        r_mem_add <= (w_grant == REQ_D) ? d_addr_i : i_addr_i;
                        r_mem_re  <= 1'b1;
                        r_state   <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE, ARB_WAIT: begin
                    // A zero-latency memory may answer in the strobe cycle itself.
                    if (mem_valid_i) begin
                        // The line is latched regardless; the pulse is suppressed
                        // when the owner has already abandoned its request.
                        if (r_owner == REQ_D) begin
                            r_d_data  <= mem_data_i;
                            r_d_valid <= d_req_i;
                        end else begin
                            r_i_data  <= mem_data_i;
                            r_i_valid <= i_req_i;
                        end
                        r_state <= ARB_RESP;
                    end else begin
                        r_state <= ARB_WAIT;
                    end
                end
                // Dead cycle so the served requester can drop its level request
                // before the next arbitration.
                ARB_RESP: r_state <= ARB_IDLE;
                default:  r_state <= ARB_IDLE;
            endcase
        end
    end

    assign mem_re_o  = r_mem_re;
    assign mem_add_o = r_mem_add;
    assign i_valid_o = r_i_valid;
    assign d_valid_o = r_d_valid;
    assign i_data_o  = r_i_data;
    assign d_data_o  = r_d_data;

`ifdef ARB_PERF_EN
    logic [31:0] r_perf_i;
    logic [31:0] r_perf_d;
    logic [31:0] r_perf_cfl;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_i   <= '0;
            r_perf_d   <= '0;
            r_perf_cfl <= '0;
        end else if (w_grant_now) begin
            if (w_grant == REQ_D) r_perf_d <= r_perf_d + 32'd1;
            else                  r_perf_i <= r_perf_i + 32'd1;
            if (i_req_i && d_req_i) r_perf_cfl <= r_perf_cfl + 32'd1;
        end
    end

    assign perf_i_cnt_o = r_perf_i;
    assign perf_d_cnt_o = r_perf_d;
    assign perf_cfl_o   = r_perf_cfl;
`else
    logic w_unused;
    assign w_unused     = w_grant_now;
    assign perf_i_cnt_o = 32'h0;
    assign perf_d_cnt_o = 32'h0;
    assign perf_cfl_o   = 32'h0;
`endif

endmodule

// File: tb/tb_mem_refill_arbiter.sv
`timescale 1ns/1ps
module tb_mem_refill_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ireq = 1'b0, dreq = 1'b0, mvalid = 1'b0;
    logic [AW-1:0] iaddr = '0, daddr = '0;
    logic [LW-1:0] mdata = '0;
    logic          i_valid_o, d_valid_o, mem_re_o;
    logic [LW-1:0] i_data_o, d_data_o;
    logic [AW-1:0] mem_add_o;
    logic [31:0]   perf_i_cnt_o, perf_d_cnt_o, perf_cfl_o;

    always #5 clk = ~clk;

    mem_refill_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk_i(clk), .rst_i(rst),
        .i_req_i(ireq), .i_addr_i(iaddr), .i_valid_o(i_valid_o), .i_data_o(i_data_o),
        .d_req_i(dreq), .d_addr_i(daddr), .d_valid_o(d_valid_o), .d_data_o(d_data_o),
        .mem_re_o(mem_re_o), .mem_add_o(mem_add_o),
        .mem_valid_i(mvalid), .mem_data_i(mdata),
        .perf_i_cnt_o(perf_i_cnt_o), .perf_d_cnt_o(perf_d_cnt_o), .perf_cfl_o(perf_cfl_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk1(input string nm, input logic a, input logic e);
        n_vec++;
        if (a !== e) begin n_err++; $display("FAIL %s: got %b want %b @%0t", nm, a, e, $time); end
    endtask
    task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin n_err++; $display("FAIL %s: got %h want %h @%0t", nm, a, e, $time); end
    endtask
    task automatic chk128(input string nm, input logic [LW-1:0] a, input logic [LW-1:0] e);
        n_vec++;
        if (a !== e) begin n_err++; $display("FAIL %s: got %h want %h @%0t", nm, a, e, $time); end
    endtask

    // ---------------- transaction-level reference model ----------------
    // Tracks one outstanding transaction by timestamps: the edge it was
    // granted, the edge its data was accepted, and the earliest next grant.
    int            cyc = 0, m_iss = 0, m_next = 0;
    bit            m_busy = 0, m_resp = 0, m_own = 0, m_last = 1;
    logic [AW-1:0] m_add = '0;
    logic          e_re = 0, e_iv = 0, e_dv = 0;
    logic [LW-1:0] e_data = '0;
    int unsigned   m_ci = 0, m_cd = 0, m_cf = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; m_iss = 0; m_next = 0; m_busy = 0; m_resp = 0;
            m_own = 0; m_last = 1; m_add = '0;
            e_re = 0; e_iv = 0; e_dv = 0; e_data = '0;
            m_ci = 0; m_cd = 0; m_cf = 0;
        end else begin
            cyc++;
            e_re = 0; e_iv = 0; e_dv = 0; m_resp = 0;
            if (m_busy) begin
                if (mvalid) begin
                    m_busy = 0; m_resp = 1; m_next = cyc + 2; e_data = mdata;
                    if (m_own) e_dv = dreq; else e_iv = ireq;
                end
            end else if (cyc >= m_next && (ireq || dreq)) begin
                if (ireq && dreq) begin m_own = !m_last; m_cf++; end
                else m_own = dreq;
                m_last = m_own;
                m_add  = m_own ? daddr : iaddr;
                m_iss  = cyc; m_busy = 1; e_re = 1;
                if (m_own) m_cd++; else m_ci++;
            end
        end
    end

    always @(negedge clk) begin
        chk1("mem_re", mem_re_o, e_re);
        chk1("i_valid", i_valid_o, e_iv);
        chk1("d_valid", d_valid_o, e_dv);
        if (rst || m_busy || m_resp) chk32("mem_add", mem_add_o, m_add);
        if (e_iv) chk128("i_data", i_data_o, e_data);
        if (e_dv) chk128("d_data", d_data_o, e_data);
        if (rst) begin
            chk128("rst_i_data", i_data_o, '0);
            chk128("rst_d_data", d_data_o, '0);
        end
`ifdef ARB_PERF_EN
        chk32("perf_i", perf_i_cnt_o, m_ci);
        chk32("perf_d", perf_d_cnt_o, m_cd);
        chk32("perf_cfl", perf_cfl_o, m_cf);
`else
        chk32("perf_i", perf_i_cnt_o, 32'h0);
        chk32("perf_d", perf_d_cnt_o, 32'h0);
        chk32("perf_cfl", perf_cfl_o, 32'h0);
`endif
    end

    // ---------------- stimulus: memory responder + requesters ----------------
    int            dly_fix = 1;      // <0: random latency 0..7
    bit            auto_rq = 0, abandon = 0, spur = 0, raise_all = 0;
    bit            r_out = 0;
    int            r_rem = 0;
    logic [LW-1:0] pat = '0;

    task automatic req_step(inout logic rq, inout logic [AW-1:0] ad, input logic vld);
        if (rq && vld) rq = 1'b0;
        else if (mvalid) ;  // keep request steady across a data-accept edge
        else if (!rq && (raise_all || $urandom_range(0, 2) == 0)) begin
            rq = 1'b1; ad = $urandom & ~32'hF;
        end else if (rq && abandon && $urandom_range(0, 15) == 0) rq = 1'b0;
    endtask

    // All stimulus changes land 1ns after the falling edge.
    task automatic tick();
        @(negedge clk); #1;
        mvalid = 1'b0;
        if (!r_out && mem_re_o) begin
            r_out = 1;
            r_rem = (dly_fix < 0) ? int'($urandom_range(0, 7)) : dly_fix;
        end
        if (r_out) begin
            if (r_rem == 0) begin
                mvalid = 1'b1; r_out = 0;
                mdata = (dly_fix < 0) ? {$urandom, $urandom, $urandom, $urandom} : pat;
            end else r_rem--;
        end else if (spur && !mem_re_o && $urandom_range(0, 7) == 0) begin
            mvalid = 1'b1; mdata = {$urandom, $urandom, $urandom, $urandom};
        end
        if (auto_rq) begin
            req_step(ireq, iaddr, i_valid_o);
            req_step(dreq, daddr, d_valid_o);
        end
    endtask

    task automatic do_reset(input logic ri, input logic rd);
        auto_rq = 0; r_out = 0; mvalid = 1'b0;
        rst = 1'b1; ireq = ri; dreq = rd;
        tick(); tick();
        rst = 1'b0;
    endtask

    int order[$];
    int n_i, n_d, n_re, mv_at, dv_at, k;
    logic [AW-1:0] re_add[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) tick();
        chk1("rst_re", mem_re_o, 1'b0);
        chk1("rst_iv", i_valid_o, 1'b0);
        chk32("rst_add", mem_add_o, 32'h0);
        rst = 1'b0;
        tick();

        // T2: single I request, 1-cycle memory
        dly_fix = 1; pat = {32{4'hA}};
        ireq = 1'b1; iaddr = 32'h40;
        tick(); chk1("t2_re_c1", mem_re_o, 1'b1); chk32("t2_add", mem_add_o, 32'h40);
        tick(); chk1("t2_re_c2", mem_re_o, 1'b0); chk1("t2_iv_c2", i_valid_o, 1'b0);
        tick(); chk1("t2_iv_c3", i_valid_o, 1'b1); chk1("t2_dv_c3", d_valid_o, 1'b0);
        chk128("t2_data", i_data_o, {32{4'hA}});
        ireq = 1'b0;
        tick(); chk1("t2_iv_c4", i_valid_o, 1'b0);
        tick();

        // T1: reset in WAIT, late memory data must be ignored
        dly_fix = 6; pat = {32{4'h5}};
        ireq = 1'b1; iaddr = 32'h80;
        tick(); chk32("t1_add", mem_add_o, 32'h80);
        tick(); tick();
        rst = 1'b1; ireq = 1'b0;
        #1;
        chk1("t1_re", mem_re_o, 1'b0);
        chk32("t1_add0", mem_add_o, 32'h0);
        chk128("t1_idata0", i_data_o, '0);
        chk1("t1_iv", i_valid_o, 1'b0);
        chk32("t1_perf_i", perf_i_cnt_o, 32'h0);
        tick(); rst = 1'b0;
        n_i = 0; n_d = 0;
        repeat (12) begin tick(); n_i += int'(i_valid_o); n_d += int'(d_valid_o); end
        chk32("t1_no_pulse", n_i + n_d, 0);

        // T3: repeated ties alternate I, D, I, D
        do_reset(1'b1, 1'b1);
        dly_fix = 1; auto_rq = 1; raise_all = 1; abandon = 0; spur = 0;
        order.delete();
        k = 0;
        while (order.size() < 4 && k < 200) begin
            tick(); k++;
            if (i_valid_o) order.push_back(0);
            if (d_valid_o) order.push_back(1);
`ifdef ARB_PERF_EN
            if (order.size() == 4) chk32("t3_cfl4", perf_cfl_o, 32'd4);
`endif
        end
        chk32("t3_count", order.size(), 4);
        for (int j = 0; j < 4 && j < order.size(); j++)
            chk32("t3_order", order[j], j % 2);

        // T4: slow memory, 7-cycle delay on a D refill
        do_reset(1'b0, 1'b0);
        dly_fix = 7; pat = {4{32'hD00D_F00D}};
        dreq = 1'b1; daddr = 32'h1230;
        n_re = 0; n_i = 0; mv_at = -1; dv_at = -1;
        for (int c = 0; c < 30; c++) begin
            tick();
            n_re += int'(mem_re_o); n_i += int'(i_valid_o);
            if (mvalid && mv_at < 0) mv_at = c;
            if (d_valid_o) begin
                if (dv_at < 0) dv_at = c;
                chk128("t4_data", d_data_o, {4{32'hD00D_F00D}});
                dreq = 1'b0;
            end
        end
        chk32("t4_re_once", n_re, 1);
        chk32("t4_dv_lat", dv_at, mv_at + 1);
        chk32("t4_no_i", n_i, 0);

        // T5: I drops its request in WAIT, pending D is served next
        do_reset(1'b0, 1'b0);
        dly_fix = 4; pat = {32{4'hC}};
        ireq = 1'b1; iaddr = 32'h100;
        tick(); dreq = 1'b1; daddr = 32'h200;
        tick(); tick(); ireq = 1'b0;
        n_i = 0; n_d = 0; re_add.delete();
        for (int c = 0; c < 30; c++) begin
            tick();
            n_i += int'(i_valid_o); n_d += int'(d_valid_o);
            if (mem_re_o) re_add.push_back(mem_add_o);
            if (d_valid_o) dreq = 1'b0;
        end
        chk32("t5_no_i", n_i, 0);
        chk32("t5_one_d", n_d, 1);
        chk32("t5_regrants", re_add.size(), 1);
        if (re_add.size() > 0) chk32("t5_d_addr", re_add[0], 32'h200);

        // randomized traffic: random latency, spurious valids, abandoned requests
        do_reset(1'b0, 1'b0);
        dly_fix = -1; auto_rq = 1; raise_all = 0; abandon = 1; spur = 1;
        n_re = 0;
        repeat (3000) begin tick(); n_re += int'(mem_re_o); end

        // T6: counters after many grants
        chk1("t6_grants", n_re >= 10, 1'b1);
`ifndef ARB_PERF_EN
        chk32("t6_perf_i", perf_i_cnt_o, 32'h0);
        chk32("t6_perf_d", perf_d_cnt_o, 32'h0);
        chk32("t6_perf_cfl", perf_cfl_o, 32'h0);
`else
        chk32("t6_perf_sum", perf_i_cnt_o + perf_d_cnt_o, n_re);
`endif

        auto_rq = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
